// File: rtl/panda_uart_tx.sv
// panda_uart_tx: bus-mapped UART transmitter with a byte FIFO.
// Register map (word index): 0 TXDATA (W), 1 STATUS (R/W1C), 2 DIV (R/W), 3 reserved.
// The bus has the same timing as a synchronous RAM: one access per cycle, never stalls.
// Read data is registered and appears in the cycle after ce_i.
// A write cycle returns the register value from before the write (read-first).
// Each serial bit lasts DIV+1 cycles. DIV is sampled at every bit boundary.
module panda_uart_tx #(
  parameter logic [15:0] ClkDiv    = 16'd867,
  parameter int unsigned FifoDepth = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ce_i,
  input  logic [3:0]  we_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_o,
  output logic        irq_o,
  output logic [1:0]  fsm_state
);

  localparam int unsigned AW = $clog2(FifoDepth);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_e;

  state_e      state, state_n;
  logic [7:0]  shift, shift_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [15:0] baud_cnt, baud_n;
  logic        tx_n;
  logic        pop;

  logic [7:0]  mem [FifoDepth];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty;
  logic [15:0] div;
  logic        ovf;
  logic        busy;

  // Bus decode. A write is any access with at least one byte enable set.
  logic wr_access, push_req, push_ok, ovf_clr;
  logic unused_bits;

  assign wr_access   = ce_i && (we_i != 4'd0);
  assign push_req    = wr_access && (addr_i == 2'd0) && we_i[0];
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted then.
  assign push_ok     = push_req && (!full || pop);
  assign ovf_clr     = wr_access && (addr_i == 2'd1) && we_i[0] && data_i[3];
  assign unused_bits = ^data_i[31:16];

  // Full and empty come from the pointers. The extra top bit tells a full FIFO from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign busy  = (state != IDLE);
  assign irq_o = empty && !busy;
  assign fsm_state = state;

  // FIFO storage. It has no reset: entries are only read when the pointers say they are valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= data_i[7:0];
  end

  // FIFO pointers. Reset empties the FIFO and discards anything queued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PtrOne;
      if (pop)     rd_ptr <= rd_ptr + PtrOne;
    end
  end

  // DIV register (byte-writable) and the sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div <= ClkDiv;
      ovf <= 1'b0;
    end else begin
      if (wr_access && (addr_i == 2'd2)) begin
        if (we_i[0]) div[7:0]  <= data_i[7:0];
        if (we_i[1]) div[15:8] <= data_i[15:8];
      end
      if (push_req && full && !pop) ovf <= 1'b1;
      else if (ovf_clr)             ovf <= 1'b0;
    end
  end

  // Registered read port. It updates only on an access and captures the value from before any write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o <= '0;
    end else if (ce_i) begin
      case (addr_i)
        2'd1:    data_o <= {28'd0, ovf, busy, empty, full};
        2'd2:    data_o <= {16'd0, div};
        default: data_o <= '0;
      endcase
    end
  end

  // Transmit FSM state register. tx_o is a flop, so the line cannot glitch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      tx_o     <= 1'b1;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      bit_cnt  <= bit_n;
      baud_cnt <= baud_n;
      tx_o     <= tx_n;
    end
  end

  // Transmit FSM next-state logic. Every bit reloads the counter from DIV.
  always_comb begin
    state_n = state;
    shift_n = shift;
    bit_n   = bit_cnt;
    baud_n  = baud_cnt;
    tx_n    = tx_o;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr[AW-1:0]];
          baud_n  = div;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (baud_cnt == 16'd0) begin
          state_n = DATA;
          baud_n  = div;
          bit_n   = 3'd0;
          tx_n    = shift[0];
        end else begin
          baud_n = baud_cnt - 16'd1;
        end
      end
      DATA: begin
        if (baud_cnt == 16'd0) begin
          baud_n = div;
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n   = bit_cnt + 3'd1;
            shift_n = {1'b0, shift[7:1]};
            tx_n    = shift[1];
          end
        end else begin
          baud_n = baud_cnt - 16'd1;
        end
      end
      STOP: begin
        if (baud_cnt == 16'd0) begin
          if (!empty) begin
            // The next frame follows with no idle gap.
            pop     = 1'b1;
            shift_n = mem[rd_ptr[AW-1:0]];
            baud_n  = div;
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_cnt - 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_panda_uart_tx.sv
// Directed testbench for panda_uart_tx.
// Inputs are driven on the falling clock edge, and outputs are sampled on the falling edge.
module tb_panda_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic [3:0]  we = 4'd0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  int fall_cnt = 0;

  panda_uart_tx dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .ce_i     (ce),
    .we_i     (we),
    .addr_i   (addr),
    .data_i   (wdata),
    .data_o   (rdata),
    .tx_o     (tx),
    .irq_o    (irq),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Count frame starts; with stop bit high every frame begins with a falling edge.
  always @(negedge tx) fall_cnt = fall_cnt + 1;

  // Reference serial frame, index 0 = start bit.
  function automatic logic [9:0] frame_bits(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // driver tasks
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] w);
    @(negedge clk);
    ce = 1'b1; addr = a; wdata = d; we = w;
    @(negedge clk);
    ce = 1'b0; we = 4'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    ce = 1'b1; addr = a; we = 4'd0;
    @(negedge clk);
    ce = 1'b0;
    d = rdata;
  endtask

  task automatic test_reset;
    logic [31:0] r;
    repeat (3) @(negedge clk);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL reset_irq: got %b expected 1", irq); end
    n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    rst_n = 1'b1;
    bus_read(2'd1, r);
    n_checks++; if (r !== 32'h2) begin n_fail++; $display("FAIL reset_status: got %h expected 00000002", r); end
    bus_read(2'd2, r);
    n_checks++; if (r !== 32'd867) begin n_fail++; $display("FAIL reset_div: got %0d expected 867", r); end
  endtask

  task automatic test_regmap;
    logic [31:0] r;
    bus_read(2'd0, r);
    n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL txdata_read: got %h expected 0", r); end
    bus_write(2'd3, 32'hDEADBEEF, 4'hF);
    bus_read(2'd3, r);
    n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL reserved_read: got %h expected 0", r); end
    // Upper byte enables alone must not push.
    bus_write(2'd0, 32'h55, 4'b1110);
    bus_read(2'd1, r);
    n_checks++; if (r !== 32'h2) begin n_fail++; $display("FAIL no_push_upper_we: got %h expected 00000002", r); end
  endtask

  task automatic test_single_frame;
    logic [9:0] f;
    f = frame_bits(8'hA5);
    bus_write(2'd2, 32'd3, 4'b0011);
    bus_write(2'd0, 32'hA5, 4'b0001);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_checks++;
      if (tx !== f[i/4]) begin n_fail++; $display("FAIL frame_a5_bit%0d: got %b expected %b", i, tx, f[i/4]); end
      n_checks++;
      if (fsm_state === 2'd0) begin n_fail++; $display("FAIL frame_a5_busy%0d: got idle expected busy", i); end
    end
    @(negedge clk);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL frame_a5_idle_tx: got %b expected 1", tx); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL frame_a5_irq: got %b expected 1", irq); end
    n_checks++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL frame_a5_state: got %0d expected 0", fsm_state); end
  endtask

  task automatic test_back_to_back;
    logic [9:0] f0, f1;
    logic       e;
    f0 = frame_bits(8'h00);
    f1 = frame_bits(8'hFF);
    fall_cnt = 0;
    @(negedge clk);
    ce = 1'b1; we = 4'b0001; addr = 2'd0; wdata = 32'h00;
    @(negedge clk);
    wdata = 32'hFF;
    @(negedge clk);
    ce = 1'b0; we = 4'd0;
    for (int i = 0; i < 80; i++) begin
      if (i > 0) @(negedge clk);
      e = (i < 40) ? f0[i/4] : f1[(i-40)/4];
      n_checks++;
      if (tx !== e) begin n_fail++; $display("FAIL b2b_bit%0d: got %b expected %b", i, tx, e); end
      n_checks++;
      if (fsm_state === 2'd0) begin n_fail++; $display("FAIL b2b_gap%0d: got idle expected busy", i); end
    end
    @(negedge clk);
    n_checks++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL b2b_end_state: got %0d expected 0", fsm_state); end
    n_checks++; if (fall_cnt !== 2) begin n_fail++; $display("FAIL b2b_frames: got %0d expected 2", fall_cnt); end
  endtask

  task automatic test_div_zero;
    logic [9:0] f;
    f = frame_bits(8'h5A);
    bus_write(2'd2, 32'd0, 4'b0011);
    bus_write(2'd0, 32'h5A, 4'b0001);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (tx !== f[i]) begin n_fail++; $display("FAIL div0_bit%0d: got %b expected %b", i, tx, f[i]); end
    end
    @(negedge clk);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL div0_irq: got %b expected 1", irq); end
  endtask

  task automatic test_overflow;
    logic [31:0] r;
    int          waited;
    bus_write(2'd2, 32'd100, 4'b0011);
    fall_cnt = 0;
    @(negedge clk);
    ce = 1'b1; we = 4'b0001; addr = 2'd0; wdata = 32'hFF;
    repeat (10) @(negedge clk);
    ce = 1'b0; we = 4'd0;
    bus_read(2'd1, r);
    n_checks++; if (r !== 32'h0D) begin n_fail++; $display("FAIL ovf_status: got %h expected 0000000d", r); end
    // Writing with bit 3 clear leaves overflow set.
    bus_write(2'd1, 32'h7, 4'b0001);
    bus_read(2'd1, r);
    n_checks++; if (r !== 32'h0D) begin n_fail++; $display("FAIL ovf_w0: got %h expected 0000000d", r); end
    bus_write(2'd1, 32'h8, 4'b0001);
    bus_read(2'd1, r);
    n_checks++; if (r !== 32'h05) begin n_fail++; $display("FAIL ovf_clear: got %h expected 00000005", r); end
    waited = 0;
    while (irq !== 1'b1 && waited < 12000) begin
      @(negedge clk);
      waited++;
    end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL ovf_drain: got irq %b expected 1 within 12000 cycles", irq); end
    n_checks++; if (fall_cnt !== 9) begin n_fail++; $display("FAIL ovf_frames: got %0d expected 9", fall_cnt); end
  endtask

  task automatic test_read_first;
    logic [31:0] r;
    @(negedge clk);
    ce = 1'b1; we = 4'b0011; addr = 2'd2; wdata = 32'h1234;
    @(negedge clk);
    n_checks++; if (rdata !== 32'd100) begin n_fail++; $display("FAIL rf_old: got %h expected 00000064", rdata); end
    we = 4'd0;
    @(negedge clk);
    ce = 1'b0;
    n_checks++; if (rdata !== 32'h1234) begin n_fail++; $display("FAIL rf_new: got %h expected 00001234", rdata); end
    @(negedge clk);
    n_checks++; if (rdata !== 32'h1234) begin n_fail++; $display("FAIL rf_hold: got %h expected 00001234", rdata); end
    bus_write(2'd2, 32'hFFAB, 4'b0001);
    bus_read(2'd2, r);
    n_checks++; if (r !== 32'h12AB) begin n_fail++; $display("FAIL div_low_byte: got %h expected 000012ab", r); end
  endtask

  task automatic test_mid_reset;
    logic [31:0] r;
    int          waited;
    bus_write(2'd2, 32'd3, 4'b0011);
    bus_write(2'd0, 32'h11, 4'b0001);
    bus_write(2'd0, 32'h22, 4'b0001);
    bus_write(2'd0, 32'h33, 4'b0001);
    waited = 0;
    while (fsm_state !== 2'd2 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_checks++; if (fsm_state !== 2'd2) begin n_fail++; $display("FAIL mr_reach_data: got %0d expected 2", fsm_state); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL mr_tx: got %b expected 1", tx); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL mr_irq: got %b expected 1", irq); end
    n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL mr_rdata: got %h expected 0", rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    fall_cnt = 0;
    bus_read(2'd1, r);
    n_checks++; if (r !== 32'h2) begin n_fail++; $display("FAIL mr_status: got %h expected 00000002", r); end
    bus_read(2'd2, r);
    n_checks++; if (r !== 32'd867) begin n_fail++; $display("FAIL mr_div: got %0d expected 867", r); end
    repeat (100) @(negedge clk);
    n_checks++; if (fall_cnt !== 0) begin n_fail++; $display("FAIL mr_no_frames: got %0d expected 0", fall_cnt); end
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL mr_idle_tx: got %b expected 1", tx); end
  endtask

  initial begin
    test_reset();
    test_regmap();
    test_single_frame();
    test_back_to_back();
    test_div_zero();
    test_overflow();
    test_read_first();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
